// File: rtl/rf_write_sched.sv
// rf_write_sched: arbitrates the register file's single write port between
// core writeback, a buffered multiply/divide result stream and a debug port.
// After reset it zero-fills registers 1..31 before letting the core run.
module rf_write_sched #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_we,
    input  logic [4:0]  core_wa,
    input  logic [31:0] core_wd,
    output logic        core_stall,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_wa,
    input  logic [31:0] dbg_wd,
    output logic        busy,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  clr_idx_q, clr_idx_d;
    logic [7:0]  starve_q, starve_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, wr_ptr_q;
    logic [4:0]  fifo_wa_q [2];
    logic [31:0] fifo_wd_q [2];

    logic        fifo_empty, fifo_full, starved;
    logic        push, pop, grant;
    logic [4:0]  head_wa;
    logic [31:0] head_wd;

    assign fifo_empty = (count_q == 2'd0);
    assign fifo_full  = (count_q == 2'd2);
    assign head_wa    = fifo_wa_q[rd_ptr_q];
    assign head_wd    = fifo_wd_q[rd_ptr_q];
    // Starvation is judged purely from registered state so core_stall has no
    // combinational path from any input.
    assign starved    = (state_q == ST_RUN) && !fifo_empty && (starve_q >= LIMIT);
    assign push       = mdu_valid && mdu_ready;

    // Next-state, grant selection and all port outputs.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        busy       = 1'b0;
        core_stall = 1'b0;
        mdu_ready  = 1'b0;
        dbg_ready  = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = 5'd0;
        rf_wd      = 32'd0;
        pop        = 1'b0;
        grant      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy       = 1'b1;
                core_stall = 1'b1;
                rf_we      = 1'b1;
                rf_wa      = clr_idx_q;
                clr_idx_d  = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mdu_ready = !fifo_full;
                if (starved) begin
                    core_stall = 1'b1;
                    pop        = 1'b1;
                    grant      = 1'b1;
                    rf_wa      = head_wa;
                    rf_wd      = head_wd;
                end else if (core_we) begin
                    grant = 1'b1;
                    rf_wa = core_wa;
                    rf_wd = core_wd;
                end else if (!fifo_empty) begin
                    pop   = 1'b1;
                    grant = 1'b1;
                    rf_wa = head_wa;
                    rf_wd = head_wd;
                end else if (dbg_valid) begin
                    dbg_ready = 1'b1;
                    grant     = 1'b1;
                    rf_wa     = dbg_wa;
                    rf_wd     = dbg_wd;
                end
                // Register 0 is hardwired zero: the grant is consumed but no write.
                rf_we = grant && (rf_wa != 5'd0);
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // FIFO occupancy and starve counter next values.
    always_comb begin
        count_d  = count_q;
        starve_d = starve_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (pop) begin
            starve_d = 8'd0;
        end else if (!fifo_empty && (starve_q < LIMIT)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= 5'd1;
            starve_q  <= 8'd0;
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            starve_q  <= starve_d;
            count_q   <= count_d;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            if (push) wr_ptr_q <= ~wr_ptr_q;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == 1'(gi))) begin
                    fifo_wa_q[gi] <= mdu_wa;
                    fifo_wd_q[gi] <= mdu_wd;
                end
            end
        end
    endgenerate

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler for the 32x32 MIPS register file. It shares the file's single write port (we/wa/wd) among three sources: core writeback, a multi-cycle multiply/divide unit (MDU) and a debug/loader port. After reset it zero-fills registers 1..31 before the core may run. It sits between the single-cycle datapath and the register file, whose read ports it does not touch.

## Interface
- STARVE_LIMIT, 8: cycles a pending MDU result may wait before the core is stalled for it (1..255).
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- core_we  in  1  core writeback request this cycle.
- core_wa  in  5  core destination register.
- core_wd  in  32  core write data.
- core_stall  out  1  core must not commit this cycle; it holds its instruction.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  result accepted on this edge when mdu_valid=1.
- mdu_wa  in  5  MDU destination register.
- mdu_wd  in  32  MDU result.
- dbg_valid  in  1  debug write request; held stable until accepted.
- dbg_ready  out  1  debug write performed on this edge.
- dbg_wa  in  5  debug destination register.
- dbg_wd  in  32  debug write data.
- busy  out  1  zero-fill in progress.
- rf_we  out  1  to register-file we.
- rf_wa  out  5  to register-file wa.
- rf_wd  out  32  to register-file wd.

## Operation
- States: CLEAR, RUN. Reset puts the block in CLEAR with clr_idx=1, MDU buffer empty and starve counter 0.
- CLEAR: drives rf_we=1, rf_wa=clr_idx, rf_wd=0, with busy=1, core_stall=1, mdu_ready=0 and dbg_ready=0. clr_idx increments every cycle. After the write to register 31 the block moves to RUN. The fill therefore takes 31 cycles.
- RUN, MDU buffer: 2-entry FIFO. mdu_ready = !full, computed from registered occupancy only. A push and a pop in the same cycle are legal when the FIFO holds 1 entry.
- RUN, starve counter: increments each cycle the FIFO is non-empty and the head is not popped. It saturates at STARVE_LIMIT and clears on a pop.
- RUN, grant priority (one winner per cycle):
  - 1. MDU head, if the counter has reached STARVE_LIMIT. The block asserts core_stall=1 for that cycle only.
  - 2. Core, if core_we=1.
  - 3. MDU head, if the FIFO is non-empty.
  - 4. Debug, if dbg_valid=1. The block asserts dbg_ready=1.
- The winner's wa/wd drive rf_wa/rf_wd.
- Writes to register 0 are consumed as a grant but drive rf_we=0 (FIFO pop or dbg_ready still occurs).
- No grant: rf_we=0, with rf_wa and rf_wd at 0.
- core_stall=0 in RUN except in the starvation cycle. The block never stalls the core merely because a request is present.

## Timing
- Core path: combinational pass-through, zero latency. The register file writes on the same edge the core commits.
- MDU: a result accepted on edge N can reach rf_we in cycle N+1 at the earliest.
- Debug: dbg_ready is combinational in the grant cycle. The write occurs on that edge.
- core_stall, busy and mdu_ready depend only on registered state, so no combinational loop can form through the core.
- Reset dominates: rst_n=0 on any edge aborts RUN or CLEAR mid-operation, drops FIFO contents and restarts CLEAR.
- Reset values (cycle after the rst_n=0 edge): busy=1, core_stall=1, mdu_ready=0, dbg_ready=0, rf_we=1, rf_wa=1, rf_wd=0.
- Worst-case MDU wait with a core write every cycle: STARVE_LIMIT cycles.

## Test plan
- Reset then idle -> rf_we=1 for exactly 31 cycles with rf_wa sequencing 1..31 and rf_wd=0. busy falls after wa=31. All 31 registers read back 0.
- RUN, core_we=1 wa=5 wd=0xDEADBEEF together with mdu_valid=1 -> core written same cycle. MDU entry buffered and written the next cycle core_we=0.
- Continuous core_we=1 with one MDU result pending, STARVE_LIMIT=8 -> core_stall=1 on exactly the 9th pending cycle (counter reaches 8), MDU written then, core resumes next cycle.
- Three back-to-back mdu_valid with core writing every cycle -> mdu_ready drops after 2 accepts and the third is held. No entry lost or reordered.
- dbg_valid wa=0 wd=0x1234 in an idle RUN cycle -> dbg_ready=1, rf_we=0, register 0 unchanged. Then dbg wa=7 -> rf_we=1, reg 7=0x1234.
- rst_n=0 pulsed mid-CLEAR (clr_idx=12) and again with FIFO full -> CLEAR restarts at register 1, FIFO empty, no buffered MDU write appears.
